// File: rtl/axi_lite_sram_slave_pkg.sv
// Shared types for the AXI4-Lite SRAM responder: response codes, FSM state
// encodings and the address-offset helper used by both channels.
package axi_lite_sram_slave_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_COMMIT = 2'd1,
    W_RESP   = 2'd2
  } wr_state_e;

  // Byte offset of an address from the window base; wraps modulo 2^32.
  function automatic logic [ADDR_W-1:0] byte_offset(input logic [ADDR_W-1:0] addr,
                                                    input logic [ADDR_W-1:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/axi_lite_sram_slave_if.sv
// AXI4-Lite bus bundle between the cache master port and the SRAM responder.
interface axi_lite_sram_slave_if;
  import axi_lite_sram_slave_pkg::*;

  logic [ADDR_W-1:0] saraddr;
  logic              sarvalid;
  logic              sarready;
  logic [DATA_W-1:0] srdata;
  logic [1:0]        srresp;
  logic              srvalid;
  logic              srready;
  logic [ADDR_W-1:0] sawaddr;
  logic              sawvalid;
  logic              sawready;
  logic [DATA_W-1:0] swdata;
  logic [STRB_W-1:0] swstrb;
  logic              swvalid;
  logic              swready;
  logic [1:0]        sbresp;
  logic              sbvalid;
  logic              sbready;

  modport slave (
    input  saraddr, sarvalid, srready, sawaddr, sawvalid, swdata, swstrb, swvalid, sbready,
    output sarready, srdata, srresp, srvalid, sawready, swready, sbresp, sbvalid
  );

  modport master (
    output saraddr, sarvalid, srready, sawaddr, sawvalid, swdata, swstrb, swvalid, sbready,
    input  sarready, srdata, srresp, srvalid, sawready, swready, sbresp, sbvalid
  );

endinterface

// File: rtl/axi_lite_sram_slave_sram_bank.sv
// Word SRAM with one asynchronous read port and one byte-enabled write port.
// Contents are never reset.
module sram_bank
  import axi_lite_sram_slave_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = 10
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [STRB_W-1:0] wr_be,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite SRAM responder with independent read and write FSMs.
// Build option: AXI_SRAM_ERR_RESP_EN makes out-of-window accesses return SLVERR.
module axi_lite_sram_slave
  import axi_lite_sram_slave_pkg::*;
#(
  parameter int unsigned       DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
  parameter int unsigned       RD_LAT = 2
) (
  input logic                  clk,
  input logic                  rst,
  axi_lite_sram_slave_if.slave bus
);

  localparam int unsigned       IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       CNT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4 * DEPTH);
`ifdef AXI_SRAM_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] addr);
    return IDX_W'(byte_offset(addr, BASE) >> 2);
  endfunction

  function automatic logic err_of(input logic [ADDR_W-1:0] addr);
    return ERR_EN && (byte_offset(addr, BASE) >= SPAN);
  endfunction

  // live_q holds the readies low for the cycle in which reset is released.
  logic live_q;

  rd_state_e         rd_state_q, rd_state_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic              rd_err_q, rd_err_d;
  logic [DATA_W-1:0] srdata_q, srdata_d;
  logic [1:0]        srresp_q, srresp_d;
  logic              rd_sample, rd_sample_err;
  logic [IDX_W-1:0]  mem_rd_idx;
  logic [DATA_W-1:0] mem_rd_data;

  wr_state_e         wr_state_q, wr_state_d;
  logic              aw_have_q, aw_have_d, w_have_q, w_have_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic              wr_err_q, wr_err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [1:0]        sbresp_q, sbresp_d;
  logic              aw_fire, w_fire, mem_we;
  logic [STRB_W-1:0] mem_be;

  // In R_IDLE the bank is addressed straight from the bus so RD_LAT = 0 can sample at accept.
  assign mem_rd_idx = (rd_state_q == R_IDLE) ? idx_of(bus.saraddr) : rd_idx_q;

  always_comb begin
    rd_state_d    = rd_state_q;
    rd_cnt_d      = rd_cnt_q;
    rd_idx_d      = rd_idx_q;
    rd_err_d      = rd_err_q;
    srdata_d      = srdata_q;
    srresp_d      = srresp_q;
    rd_sample     = 1'b0;
    rd_sample_err = rd_err_q;
    bus.sarready  = 1'b0;
    bus.srvalid   = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        bus.sarready = live_q;
        if (live_q && bus.sarvalid) begin
          rd_idx_d = idx_of(bus.saraddr);
          rd_err_d = err_of(bus.saraddr);
          rd_cnt_d = CNT_W'(RD_LAT);
          if (RD_LAT == 0) begin
            rd_sample     = 1'b1;
            rd_sample_err = rd_err_d;
            rd_state_d    = R_RESP;
          end else begin
            rd_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        rd_cnt_d = rd_cnt_q - CNT_W'(1);
        if (rd_cnt_d == '0) begin
          rd_sample  = 1'b1;
          rd_state_d = R_RESP;
        end
      end
      R_RESP: begin
        bus.srvalid = 1'b1;
        if (bus.srready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
    if (rd_sample) begin
      srdata_d = rd_sample_err ? '0 : mem_rd_data;
      srresp_d = rd_sample_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign aw_fire = (wr_state_q == W_IDLE) && live_q && !aw_have_q && bus.sawvalid;
  assign w_fire  = (wr_state_q == W_IDLE) && live_q && !w_have_q && bus.swvalid;

  always_comb begin
    wr_state_d   = wr_state_q;
    aw_have_d    = aw_have_q;
    w_have_d     = w_have_q;
    wr_idx_d     = wr_idx_q;
    wr_err_d     = wr_err_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    sbresp_d     = sbresp_q;
    mem_we       = 1'b0;
    mem_be       = '0;
    bus.sawready = 1'b0;
    bus.swready  = 1'b0;
    bus.sbvalid  = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        bus.sawready = live_q && !aw_have_q;
        bus.swready  = live_q && !w_have_q;
        if (aw_fire) begin
          aw_have_d = 1'b1;
          wr_idx_d  = idx_of(bus.sawaddr);
          wr_err_d  = err_of(bus.sawaddr);
        end
        if (w_fire) begin
          w_have_d = 1'b1;
          wdata_d  = bus.swdata;
          wstrb_d  = bus.swstrb;
        end
        if (aw_have_d && w_have_d) wr_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        // A reset landing on the commit cycle must not touch the array.
        mem_we     = !wr_err_q && !rst;
        mem_be     = wstrb_q;
        sbresp_d   = wr_err_q ? RESP_SLVERR : RESP_OKAY;
        aw_have_d  = 1'b0;
        w_have_d   = 1'b0;
        wr_state_d = W_RESP;
      end
      W_RESP: begin
        bus.sbvalid = 1'b1;
        if (bus.sbready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q     <= 1'b0;
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= '0;
      srdata_q   <= '0;
      srresp_q   <= RESP_OKAY;
      wr_state_q <= W_IDLE;
      aw_have_q  <= 1'b0;
      w_have_q   <= 1'b0;
      sbresp_q   <= RESP_OKAY;
    end else begin
      live_q     <= 1'b1;
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      srdata_q   <= srdata_d;
      srresp_q   <= srresp_d;
      wr_state_q <= wr_state_d;
      aw_have_q  <= aw_have_d;
      w_have_q   <= w_have_d;
      sbresp_q   <= sbresp_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_idx_q <= rd_idx_d;
    rd_err_q <= rd_err_d;
    wr_idx_q <= wr_idx_d;
    wr_err_q <= wr_err_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
  end

  assign bus.srdata = srdata_q;
  assign bus.srresp = srresp_q;
  assign bus.sbresp = sbresp_q;

  sram_bank #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk     (clk),
    .rd_idx  (mem_rd_idx),
    .rd_data (mem_rd_data),
    .we      (mem_we),
    .wr_idx  (wr_idx_q),
    .wr_be   (mem_be),
    .wr_data (wdata_q)
  );

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Scoreboard bench for axi_lite_sram_slave: a word-array model predicts every
// R and B response; a negedge monitor compares them as the handshakes occur.
module tb_axi_lite_sram_slave;
  import axi_lite_sram_slave_pkg::*;

  localparam int unsigned DEPTH  = 1024;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          RD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_sram_slave_if bus();

  axi_lite_sram_slave #(.DEPTH(DEPTH), .BASE(BASE), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {logic [31:0] data; logic [1:0] resp;} rd_exp_t;
  rd_exp_t     rd_q[$];
  logic [1:0]  wr_q[$];
  logic [31:0] model_mem [DEPTH];
  rd_exp_t     mon_r;
  logic [1:0]  mon_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int unsigned m_idx(input logic [31:0] a);
    return ((a - BASE) >> 2) & (DEPTH - 1);
  endfunction

  function automatic bit m_err(input logic [31:0] a);
`ifdef AXI_SRAM_ERR_RESP_EN
    return !((a >= BASE) && (a < BASE + 4 * DEPTH));
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (m_err(a)) wr_q.push_back(RESP_SLVERR);
    else begin
      for (int i = 0; i < 4; i++) if (s[i]) model_mem[m_idx(a)][8*i +: 8] = d[8*i +: 8];
      wr_q.push_back(RESP_OKAY);
    end
  endtask

  task automatic model_read(input logic [31:0] a);
    rd_exp_t e;
    if (m_err(a)) e = '{data: 32'h0, resp: RESP_SLVERR};
    else          e = '{data: model_mem[m_idx(a)], resp: RESP_OKAY};
    rd_q.push_back(e);
  endtask

  // Monitor: a valid&&ready seen at negedge completes on the following posedge.
  always @(negedge clk) begin
    if (bus.srvalid && bus.srready) begin
      check("r_expected", 32'(rd_q.size() > 0), 1);
      if (rd_q.size() > 0) begin
        mon_r = rd_q.pop_front();
        check("rdata", bus.srdata, mon_r.data);
        check("rresp", 32'(bus.srresp), 32'(mon_r.resp));
      end
    end
    if (bus.sbvalid && bus.sbready) begin
      check("b_expected", 32'(wr_q.size() > 0), 1);
      if (wr_q.size() > 0) begin
        mon_b = wr_q.pop_front();
        check("bresp", 32'(bus.sbresp), 32'(mon_b));
      end
    end
  end

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_sarready"}, 32'(bus.sarready), 0);
    check({tag, "_srvalid"},  32'(bus.srvalid), 0);
    check({tag, "_srdata"},   bus.srdata, 0);
    check({tag, "_srresp"},   32'(bus.srresp), 0);
    check({tag, "_sawready"}, 32'(bus.sawready), 0);
    check({tag, "_swready"},  32'(bus.swready), 0);
    check({tag, "_sbvalid"},  32'(bus.sbvalid), 0);
    check({tag, "_sbresp"},   32'(bus.sbresp), 0);
  endtask

  task automatic check_ready_after_release(input string tag);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_sarready_up"}, 32'(bus.sarready), 1);
    check({tag, "_sawready_up"}, 32'(bus.sawready), 1);
    check({tag, "_swready_up"},  32'(bus.swready), 1);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input bit pre_b, input int bhold,
                          input bit chk_order);
    bit aw_done, w_done, aw_hs, w_hs, done;
    int waited;
    aw_done = 0; w_done = 0;
    bus.sawaddr = addr; bus.swdata = data; bus.swstrb = strb; bus.sbready = pre_b;
    for (int t = 0; t < 40 && !(aw_done && w_done); t++) begin
      bus.sawvalid = !aw_done && (t >= aw_dly);
      bus.swvalid  = !w_done && (t >= w_dly);
      @(negedge clk);
      if (chk_order && w_done && !aw_done) check("swready_low_after_w", 32'(bus.swready), 0);
      aw_hs = bus.sawvalid && bus.sawready;
      w_hs  = bus.swvalid && bus.swready;
      @(posedge clk); #1;
      aw_done |= aw_hs;
      w_done  |= w_hs;
    end
    bus.sawvalid = 0; bus.swvalid = 0;
    check("aw_w_accepted", 32'(aw_done && w_done), 1);
    if (!(aw_done && w_done)) begin bus.sbready = 0; return; end
    model_write(addr, data, strb);
    done = 0; waited = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus.sbvalid && bus.sbready) done = 1;
      else if (bus.sbvalid) waited++;
      @(posedge clk); #1;
      if (waited > bhold) bus.sbready = 1;
    end
    bus.sbready = 0;
    check("b_handshake", 32'(done), 1);
    if (chk_order) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("sbvalid_single_pulse", 32'(bus.sbvalid), 0);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold, input bit pre_r);
    bit ok;
    int unsigned acc_cyc, vld_cyc;
    logic [31:0] d0;
    logic [1:0]  r0;
    bus.saraddr = addr; bus.sarvalid = 1; bus.srready = pre_r;
    ok = 0; acc_cyc = 0; vld_cyc = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (bus.sarready) begin ok = 1; acc_cyc = cyc; end
      @(posedge clk); #1;
    end
    bus.sarvalid = 0; bus.saraddr = $urandom;
    check("ar_accepted", 32'(ok), 1);
    if (!ok) begin bus.srready = 0; return; end
    model_read(addr);
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (bus.srvalid) begin ok = 1; vld_cyc = cyc; end
      else begin @(posedge clk); #1; end
    end
    check("r_valid_seen", 32'(ok), 1);
    if (!ok) begin bus.srready = 0; return; end
    check("r_latency_cycles", vld_cyc - acc_cyc, RD_LAT + 1);
    if (!pre_r) begin
      d0 = bus.srdata; r0 = bus.srresp;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check("srvalid_held", 32'(bus.srvalid), 1);
        check("srdata_stable", bus.srdata, d0);
        check("srresp_stable", 32'(bus.srresp), 32'(r0));
        check("sarready_low_in_resp", 32'(bus.sarready), 0);
      end
      @(posedge clk); #1;
      bus.srready = 1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.srready = 0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] addr, data;
    int unsigned idx;
    bus.saraddr = '0; bus.sarvalid = 0; bus.srready = 0;
    bus.sawaddr = '0; bus.sawvalid = 0; bus.swdata = '0; bus.swstrb = '0;
    bus.swvalid = 0; bus.sbready = 0;
    foreach (model_mem[i]) model_mem[i] = 'x;

    // Reset: all outputs quiet, readies come up after release.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_quiet_outputs("reset");
    @(posedge clk); #1;
    rst = 0;
    check_ready_after_release("release");

    for (int i = 0; i < 32; i++)
      do_write(BASE + 32'(i * 4), $urandom, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2),
               1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);

    // Full-word write and readback, ready already high for the R handshake.
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, 0, 0);
    do_read(32'h8000_0010, 0, 1);
    // Single byte lane overwrite.
    do_write(32'h8000_0010, 32'h0000_00AA, 4'b0001, 0, 0, 0, 1, 0);
    do_read(32'h8000_0010, 0, 0);
    // W three cycles ahead of AW.
    do_write(32'h8000_001C, 32'h1234_5678, 4'hF, 3, 0, 0, 0, 1);
    do_read(32'h8000_001C, 0, 1);
    // Hold srready low across a response.
    do_read(32'h8000_0008, 5, 0);
    // One word past the window.
    do_read(32'h8000_1000, 0, 1);
    // Zero strobe: no change, still a response.
    do_write(32'h8000_0014, 32'hFFFF_FFFF, 4'h0, 1, 0, 1, 0, 0);
    do_read(32'h8000_0014, 1, 0);

    for (int k = 0; k < 80; k++) begin
      idx  = $urandom_range(0, 31);
      addr = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: addr = addr + 32'(4 * DEPTH) * 32'($urandom_range(1, 3));
        1: addr = addr - 32'(4 * DEPTH);
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        do_write(addr, data, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
      end else begin
        do_read(addr, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end

    // Reset while the read is waiting on latency.
    bus.saraddr = BASE + 32'h0C; bus.sarvalid = 1;
    @(negedge clk);
    check("abort_r_accept", 32'(bus.sarready), 1);
    @(posedge clk); #1;
    bus.sarvalid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check_quiet_outputs("rst_in_rwait");
    @(posedge clk); #1;
    rst = 0;
    check_ready_after_release("rwait_release");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no_stale_srvalid", 32'(bus.srvalid), 0);
      @(posedge clk); #1;
    end
    do_read(BASE + 32'h0C, 0, 1);

    // Reset with AW captured but W still outstanding.
    bus.sawaddr = BASE + 32'h14; bus.sawvalid = 1;
    @(negedge clk);
    check("abort_aw_accept", 32'(bus.sawready), 1);
    @(posedge clk); #1;
    bus.sawvalid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check_quiet_outputs("rst_aw_only");
    @(posedge clk); #1;
    rst = 0;
    check_ready_after_release("aw_release");
    do_write(BASE + 32'h18, 32'hCAFE_F00D, 4'hF, 2, 0, 0, 0, 1);
    do_read(BASE + 32'h14, 0, 1);
    do_read(BASE + 32'h18, 0, 0);

    repeat (4) @(posedge clk);
    check("rd_scoreboard_drained", rd_q.size(), 0);
    check("wr_scoreboard_drained", wr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
